// File: rtl/ntru_idx_pkg.sv
// Shared constants and state encoding for the NTRU-HRSS polynomial index counter.
package ntru_idx_pkg;

  localparam int N_HRSS = 701;
  localparam int IDX_W  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } idx_state_t;

endpackage

// File: rtl/poly_idx_counter_mod_step.sv
// Combinational modular step: next = (idx +/- STEP) mod MOD, with a wrap flag on carry/borrow.
module mod_step #(
  parameter int WIDTH = 10,
  parameter int MOD   = 701,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] idx,
  input  logic             dir,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);

  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MOD_N  = WIDTH'(MOD);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

  logic [WIDTH:0] sum_s;

  // The range test uses the widened sum; the result itself is exact in WIDTH-bit modular arithmetic
  always_comb begin
    sum_s = {1'b0, idx} + STEP_W;
    nxt   = idx + STEP_N;
    wrap  = 1'b0;
    if (dir) begin
      if (idx < STEP_N) begin
        nxt  = idx - STEP_N + MOD_N;
        wrap = 1'b1;
      end else begin
        nxt  = idx - STEP_N;
        wrap = 1'b0;
      end
    end else begin
      if (sum_s >= MOD_W) begin
        nxt  = idx + STEP_N - MOD_N;
        wrap = 1'b1;
      end else begin
        nxt  = idx + STEP_N;
        wrap = 1'b0;
      end
    end
  end

endmodule

// File: rtl/poly_idx_counter.sv
// Sequential polynomial index generator with valid/advance handshake and cyclic rotation by offset.
// Optional down-counting is enabled by defining POLY_IDX_DOWN_EN (adds the dir input).
module poly_idx_counter
  import ntru_idx_pkg::*;
#(
  parameter int WIDTH = IDX_W,
  parameter int MOD   = N_HRSS,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] len,
  input  logic             adv,
`ifdef POLY_IDX_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] idx,
  output logic             idx_valid,
  output logic             wrap,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  idx_state_t       state_r, state_n;
  logic [WIDTH-1:0] idx_r, idx_n;
  logic [WIDTH-1:0] rem_r, rem_n;
  logic             err_r, err_n;
  logic             wrap_r, wrap_n;
  logic             valid_r, last_r, busy_r, done_r;
  logic             dir_s, dir_n;
  logic [WIDTH-1:0] step_nxt_s;
  logic             step_wrap_s;
  logic             bad_param_s;

`ifdef POLY_IDX_DOWN_EN
  logic dir_r;
  assign dir_s = dir_r;
  assign dir_n = (state_r == IDLE && start) ? dir : dir_r;
`else
  assign dir_s = 1'b0;
  assign dir_n = 1'b0;
`endif

  mod_step #(
    .WIDTH (WIDTH),
    .MOD   (MOD),
    .STEP  (STEP)
  ) u_mod_step (
    .idx  (idx_r),
    .dir  (dir_s),
    .nxt  (step_nxt_s),
    .wrap (step_wrap_s)
  );

  assign bad_param_s = ({1'b0, start_val} >= MOD_W) || ({1'b0, len} > MOD_W);

  // Next-state, index and remaining-count logic
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    rem_n   = rem_r;
    err_n   = err_r;
    wrap_n  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (bad_param_s) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else if (len == ZERO_W) begin
            err_n   = 1'b0;
            state_n = DONE;
          end else begin
            err_n   = 1'b0;
            idx_n   = start_val;
            rem_n   = len;
            state_n = RUN;
          end
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (adv) begin
          if (rem_r == ONE_W) begin
            rem_n   = ZERO_W;
            state_n = DONE;
          end else begin
            idx_n  = step_nxt_s;
            rem_n  = rem_r - ONE_W;
            wrap_n = step_wrap_s;
          end
        end else begin
          state_n = RUN;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= ZERO_W;
      rem_r   <= ZERO_W;
      err_r   <= 1'b0;
      wrap_r  <= 1'b0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef POLY_IDX_DOWN_EN
      dir_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      rem_r   <= rem_n;
      err_r   <= err_n;
      wrap_r  <= wrap_n;
      valid_r <= (state_n == RUN);
      last_r  <= (state_n == RUN) && (rem_n == ONE_W);
      busy_r  <= (state_n != IDLE);
      done_r  <= (state_n == DONE);
`ifdef POLY_IDX_DOWN_EN
      dir_r   <= dir_n;
`endif
    end
  end

  assign idx       = idx_r;
  assign idx_valid = valid_r;
  assign wrap      = wrap_r;
  assign last      = last_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_poly_idx_counter.sv
// Directed self-checking bench for poly_idx_counter (MOD=701, STEP=1); down-count steps under POLY_IDX_DOWN_EN.
module tb_poly_idx_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] start_val = 10'd0;
  logic [9:0] len = 10'd0;
  logic       adv = 1'b0;
  logic       dir = 1'b0;
  logic [9:0] idx;
  logic       idx_valid, wrap, last, busy, done, err;

  int total = 0;
  int bad = 0;

  poly_idx_counter #(.WIDTH(10), .MOD(701), .STEP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_val (start_val),
    .len       (len),
    .adv       (adv),
`ifdef POLY_IDX_DOWN_EN
    .dir       (dir),
`endif
    .idx       (idx),
    .idx_valid (idx_valid),
    .wrap      (wrap),
    .last      (last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic kick(input logic [9:0] sv, input logic [9:0] ln);
    start_val = sv;
    len       = ln;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  initial begin
    int exp_idx;
    int wraps;

    // reset state
    step();
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_valid", 32'(idx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    rst_n = 1'b1;
    step();

    // 0,1,2 with adv held
    adv = 1'b1;
    kick(10'd0, 10'd3);
    chk("t1_v0", 32'(idx_valid), 32'd1);
    chk("t1_i0", 32'(idx), 32'd0);
    chk("t1_l0", 32'(last), 32'd0);
    chk("t1_b0", 32'(busy), 32'd1);
    step();
    chk("t1_i1", 32'(idx), 32'd1);
    chk("t1_w1", 32'(wrap), 32'd0);
    step();
    chk("t1_i2", 32'(idx), 32'd2);
    chk("t1_l2", 32'(last), 32'd1);
    chk("t1_w2", 32'(wrap), 32'd0);
    step();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_vdone", 32'(idx_valid), 32'd0);
    chk("t1_bdone", 32'(busy), 32'd1);
    step();
    chk("t1_done_off", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // wrap across 700 -> 0
    kick(10'd699, 10'd4);
    chk("t2_i0", 32'(idx), 32'd699);
    chk("t2_w0", 32'(wrap), 32'd0);
    step();
    chk("t2_i1", 32'(idx), 32'd700);
    chk("t2_w1", 32'(wrap), 32'd0);
    step();
    chk("t2_i2", 32'(idx), 32'd0);
    chk("t2_w2", 32'(wrap), 32'd1);
    step();
    chk("t2_i3", 32'(idx), 32'd1);
    chk("t2_w3", 32'(wrap), 32'd0);
    chk("t2_l3", 32'(last), 32'd1);
    step();
    chk("t2_done", 32'(done), 32'd1);
    step();

    // stalls: adv 1,0,0,1
    kick(10'd5, 10'd2);
    chk("t3_i0", 32'(idx), 32'd5);
    step();
    adv = 1'b0;
    chk("t3_i1", 32'(idx), 32'd6);
    chk("t3_l1", 32'(last), 32'd1);
    step();
    chk("t3_hold1", 32'(idx), 32'd6);
    chk("t3_vhold1", 32'(idx_valid), 32'd1);
    step();
    chk("t3_hold2", 32'(idx), 32'd6);
    adv = 1'b1;
    step();
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_vdone", 32'(idx_valid), 32'd0);
    step();
    chk("t3_idle", 32'(busy), 32'd0);

    // len == 0
    kick(10'd3, 10'd0);
    chk("t4_len0_done", 32'(done), 32'd1);
    chk("t4_len0_valid", 32'(idx_valid), 32'd0);
    chk("t4_len0_err", 32'(err), 32'd0);
    step();
    chk("t4_len0_idle", 32'(busy), 32'd0);

    // illegal start_val and len, then recovery
    kick(10'd701, 10'd1);
    chk("t4_sv_err", 32'(err), 32'd1);
    chk("t4_sv_done", 32'(done), 32'd1);
    chk("t4_sv_valid", 32'(idx_valid), 32'd0);
    step();
    chk("t4_sv_sticky", 32'(err), 32'd1);
    chk("t4_sv_nov", 32'(idx_valid), 32'd0);
    kick(10'd0, 10'd702);
    chk("t4_len_err", 32'(err), 32'd1);
    step();
    adv = 1'b0;
    kick(10'd10, 10'd1);
    chk("t4_clr_err", 32'(err), 32'd0);
    chk("t4_clr_idx", 32'(idx), 32'd10);
    chk("t4_clr_last", 32'(last), 32'd1);
    adv = 1'b1;
    step();
    chk("t4_clr_done", 32'(done), 32'd1);
    step();

    // start while busy ignored, then reset mid-run
    kick(10'd100, 10'd5);
    chk("t5_i0", 32'(idx), 32'd100);
    start_val = 10'd300;
    len       = 10'd2;
    start     = 1'b1;
    step();
    start     = 1'b0;
    chk("t5_ign_i1", 32'(idx), 32'd101);
    step();
    chk("t5_ign_i2", 32'(idx), 32'd102);
    step();
    chk("t5_ign_i3", 32'(idx), 32'd103);
    chk("t5_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_idx", 32'(idx), 32'd0);
    chk("t5_rst_valid", 32'(idx_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_last", 32'(last), 32'd0);
    step();
    chk("t5_rst_nodone", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();
    chk("t5_post_nodone", 32'(done), 32'd0);
    kick(10'd7, 10'd1);
    chk("t5_fresh_idx", 32'(idx), 32'd7);
    chk("t5_fresh_valid", 32'(idx_valid), 32'd1);
    step();
    chk("t5_fresh_done", 32'(done), 32'd1);
    step();

    // full cycle len == MOD starting at 350
    kick(10'd350, 10'd701);
    exp_idx = 350;
    wraps = 0;
    for (int i = 0; i < 701; i++) begin
      chk("t6_valid", 32'(idx_valid), 32'd1);
      chk("t6_idx", 32'(idx), 32'(exp_idx));
      chk("t6_last", 32'(last), (i == 700) ? 32'd1 : 32'd0);
      if (wrap) wraps++;
      step();
      exp_idx = (exp_idx + 1) % 701;
    end
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_wraps", 32'(wraps), 32'd1);
    step();

`ifdef POLY_IDX_DOWN_EN
    // down count 1, 0, 700
    dir = 1'b1;
    kick(10'd1, 10'd3);
    dir = 1'b0;
    chk("t7_i0", 32'(idx), 32'd1);
    step();
    chk("t7_i1", 32'(idx), 32'd0);
    chk("t7_w1", 32'(wrap), 32'd0);
    step();
    chk("t7_i2", 32'(idx), 32'd700);
    chk("t7_w2", 32'(wrap), 32'd1);
    chk("t7_l2", 32'(last), 32'd1);
    step();
    chk("t7_done", 32'(done), 32'd1);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poly_idx_counter.md
Name: poly_idx_counter

Overview:
- Parametrised, sequential successor to the fixed-width combinational incrementers used in Encaps.
- Issues a run of polynomial coefficient indices modulo MOD (default 701, the NTRU-HRSS n), starting at a loadable offset.
- Indices are handed out under a valid/advance handshake, so ternary SIPO, multiplier and packer stages can walk polynomials cyclically (rotation by offset) without local index logic.

Parameters:
- WIDTH, 10, bit width of index and length fields; must satisfy 2**WIDTH >= MOD.
- MOD, 701, modulus; indices always lie in 0..MOD-1.
- STEP, 1, increment per advance; must satisfy 1 <= STEP < MOD.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- start_val  in  WIDTH  first index of the run.
- len  in  WIDTH  number of indices to issue (0..MOD).
- adv  in  1  consumer accepts current idx this cycle.
- idx  out  WIDTH  current index.
- idx_valid  out  1  idx is valid.
- wrap  out  1  one-cycle pulse: the accepted advance crossed MOD-1 -> 0.
- last  out  1  the current idx is the final one of the run (qualified by idx_valid).
- busy  out  1  run in progress (RUN or DONE state).
- done  out  1  one-cycle pulse at the end of the run.
- err  out  1  sticky; set when start_val >= MOD or len > MOD at start; cleared by the next accepted start.

Behaviour:
- Reset: asynchronous on rst_n low. State = IDLE; idx, remaining = 0; idx_valid, wrap, last, busy, done, err = 0.
- State IDLE:
  - On start = 1, capture start_val and len.
  - If start_val >= MOD or len > MOD: set err, go to DONE. No index is issued.
  - Else if len == 0: go to DONE. No index is issued.
  - Else: load idx = start_val and remaining = len, go to RUN.
  - err is cleared on every accepted start, then reset if the new parameters are illegal.
- State RUN:
  - idx_valid = 1; last = (remaining == 1).
  - Without adv, idx is held stable.
  - On adv with remaining == 1: go to DONE.
  - On other adv: idx <= (idx + STEP) mod MOD, remaining decrements, and wrap pulses the next cycle if the sum was >= MOD.
  - Modular add: compute idx + STEP at WIDTH+1 bits; subtract MOD if the sum is >= MOD.
- State DONE (one cycle): done = 1, idx_valid = 0, then go to IDLE.
- busy = 1 in RUN and DONE.
- Latency:
  - First idx_valid is asserted the cycle after start.
  - Sustained throughput is 1 index per cycle with adv held high.
  - A run of L indices asserts done on cycle L+1 after start.
- Boundary conditions:
  - start while busy: ignored, with no effect on the current run.
  - adv while idx_valid = 0: ignored.
  - len == MOD: covers every index exactly once; wrap pulses once unless start_val == 0.
  - rst_n low mid-run: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: POLY_IDX_DOWN_EN.
- Defined:
  - Adds input port dir (1 bit), sampled at start; 0 = up, 1 = down.
  - Down mode: idx <= idx - STEP, adding MOD when the result is negative (0 -> MOD-STEP); wrap pulses on that borrow.
- Undefined: port absent; up-count only.

Decomposition:
- Package ntru_idx_pkg:
  - localparam N_HRSS = 701.
  - localparam IDX_W = 10.
  - typedef enum logic [1:0] {IDLE, RUN, DONE} idx_state_t.
- Sub-module mod_step, purely combinational:
  - Inputs: idx, dir.
  - Outputs: next index and a wrap flag.
  - Parametrised by WIDTH, MOD and STEP.
- The top level holds the FSM, the remaining counter and the output registers.

Test Plan:
- MOD=701, start_val=0, len=3, adv held high -> idx 0, 1, 2 on cycles 1-3; last with idx=2; done on cycle 4; wrap never asserted.
- start_val=699, len=4, adv=1 -> idx 699, 700, 0, 1; wrap pulses once, after the 700 -> 0 advance.
- start_val=5, len=2, adv toggled 1, 0, 0, 1 -> idx holds at 6 through the stalls; exactly 2 indices issued; done one cycle after the second adv.
- len=0 -> no idx_valid, done the cycle after start; start_val=701 -> err=1 and done with no indices; a following legal start clears err.
- Second start mid-run is ignored; rst_n pulled low at remaining=2 -> outputs go to 0 immediately, no done pulse, and a fresh run starts cleanly afterwards.
- With POLY_IDX_DOWN_EN, dir=1, start_val=1, len=3, STEP=1 -> idx 1, 0, 700; wrap pulses on the 0 -> 700 advance.
